// File: rtl/div_unit_32_bit_pkg.sv
// Shared types and constants for the iterative RV32M divider.
// Operation encoding follows the funct3 low bits of DIV/DIVU/REM/REMU.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_e;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    function automatic logic is_signed_op(div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_quot_op(div_op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/div_unit_32_bit_if.sv
// Request/response bundle between the execute stage and the divider.
interface div_unit_32_bit_if #(parameter int XLEN = 32);
    import div_pkg::*;

    // i_start is sampled only while the divider is IDLE (i_flush blocks it);
    // o_valid pulses for exactly one cycle with o_result, which then holds
    // until a later operation completes; o_busy is high in PREP/CALC/FIX.
    logic            i_start;
    div_op_e         i_op;
    logic [XLEN-1:0] i_a;
    logic [XLEN-1:0] i_b;
    logic            i_flush;
    logic            o_busy;
    logic            o_valid;
    logic [XLEN-1:0] o_result;
    div_state_e      dbg_state;

    modport master (
        output i_start, i_op, i_a, i_b, i_flush,
        input  o_busy, o_valid, o_result, dbg_state
    );

    modport slave (
        input  i_start, i_op, i_a, i_b, i_flush,
        output o_busy, o_valid, o_result, dbg_state
    );

endinterface

// File: rtl/div_unit_32_bit_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// trial-subtract the divisor over 33 bits so divisors >= 2^31 stay exact.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   r,
    input  logic            q_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   r_next,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    // The partial remainder is always below the divisor, so its top bit is zero.
    logic          unused_r_msb;

    assign unused_r_msb = r[XLEN];
    assign shifted      = {r[XLEN-1:0], q_msb};
    assign trial        = shifted - {1'b0, divisor};
    assign q_bit        = ~trial[XLEN];
    assign r_next       = q_bit ? trial : shifted;

endmodule

// File: rtl/div_unit_32_bit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Signed operands are divided as magnitudes and the sign is restored in FIX.
module div_unit_32_bit
    import div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    div_unit_32_bit_if.slave  bus
);

    div_state_e      state;
    div_state_e      state_nxt;
    div_op_e         op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] q_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN:0]   r_q;
    logic [XLEN:0]   r_step;
    logic [CNT_W-1:0] cnt;
    logic            q_bit;
    logic            neg_q;
    logic            neg_r;

    logic            signed_op;
    logic            quot_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero;
    logic            ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] fix_res;

    always_comb begin
        signed_op   = is_signed_op(op_q);
        quot_op     = is_quot_op(op_q);
        a_neg       = signed_op & a_q[XLEN-1];
        b_neg       = signed_op & b_q[XLEN-1];
        // -INT_MIN wraps to INT_MIN, which is the right magnitude read as unsigned.
        a_abs       = a_neg ? -a_q : a_q;
        b_abs       = b_neg ? -b_q : b_q;
        div_zero    = (b_q == '0);
        ovf         = signed_op && (a_q == INT_MIN) && (b_q == DIV_ZERO_Q);
        special     = div_zero || ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = quot_op ? DIV_ZERO_Q : a_q;
        end else if (quot_op) begin
            special_res = INT_MIN;
        end
        if (quot_op) begin
            fix_res = neg_q ? -q_q : q_q;
        end else begin
            fix_res = neg_r ? -r_q[XLEN-1:0] : r_q[XLEN-1:0];
        end
    end

    div_step #(.XLEN(XLEN)) u_step (
        .r       (r_q),
        .q_msb   (q_q[XLEN-1]),
        .divisor (dvs_q),
        .r_next  (r_step),
        .q_bit   (q_bit)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.i_start) state_nxt = PREP;
            PREP:    state_nxt = special ? DONE : CALC;
            CALC:    if (cnt == CNT_W'(XLEN-1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A flush drops whatever is in flight and also blocks a same-cycle start.
        if (bus.i_flush) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q     <= DIV;
            a_q      <= '0;
            b_q      <= '0;
            q_q      <= '0;
            r_q      <= '0;
            dvs_q    <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
        end else if (!bus.i_flush) begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        op_q <= bus.i_op;
                        a_q  <= bus.i_a;
                        b_q  <= bus.i_b;
                    end
                end
                PREP: begin
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    dvs_q <= b_abs;
                    if (special) begin
                        result_q <= special_res;
                    end else begin
                        r_q <= '0;
                        q_q <= a_abs;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    r_q <= r_step;
                    q_q <= {q_q[XLEN-2:0], q_bit};
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    result_q <= fix_res;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_busy    = (state == PREP) || (state == CALC) || (state == FIX);
    assign bus.o_valid   = (state == DONE);
    assign bus.o_result  = result_q;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_div_unit_32_bit.sv
// Directed bench for div_unit_32_bit: expected results go into a queue when an
// operation is issued and a negedge monitor checks each o_valid pulse against it.
module tb_div_unit_32_bit;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    div_unit_32_bit_if bus ();

    div_unit_32_bit dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int          n_vec   = 0;
    int          n_fail  = 0;
    int          n_valid = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic [31:0] mon_exp;
    string       mon_name;

    // Scoreboard monitor: every o_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.o_valid) begin
            n_valid++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: result=%h, required no pulse", bus.o_result);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                if (bus.o_result !== mon_exp) begin
                    n_fail++;
                    $display("FAIL %s: result=%h, required %h", mon_name, bus.o_result, mon_exp);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.i_op    = op;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
    endtask

    // Issues one operation and checks busy, latency from the start edge, and busy low in DONE.
    task automatic run_op(input string nm, input div_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        issue(op, a, b);
        @(negedge clk);
        lat = 0;
        check({nm, "_busy"}, 32'(bus.o_busy), 32'd1);
        while (!bus.o_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        check({nm, "_busy_done"}, 32'(bus.o_busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int valid_snap;
        bus.i_start = 1'b0;
        bus.i_op    = DIVU;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_flush = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_result", bus.o_result, 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
        rst_n = 1'b1;

        run_op("divu_100_7",  DIVU, 32'd100,        32'd7,          32'd14,         34);
        run_op("remu_100_7",  REMU, 32'd100,        32'd7,          32'd2,          34);
        run_op("div_m7_2",    DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34);
        run_op("rem_m7_2",    REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34);
        run_op("div_100_m7",  DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  34);
        run_op("rem_100_m7",  REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          34);
        run_op("div_min_2",   DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  34);
        run_op("rem_min_3",   REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  34);
        run_op("remu_big",    REMU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  34);
        run_op("divu_0_5",    DIVU, 32'd0,          32'd5,          32'd0,          34);
        run_op("divu_max_1",  DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34);
        run_op("divu_5_0",    DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
        run_op("rem_m9_0",    REM,  32'hFFFF_FFF7,  32'd0,          32'hFFFF_FFF7,  1);
        run_op("div_m1_0",    DIV,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  1);
        run_op("div_ovf",     DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
        run_op("rem_ovf",     REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);

        // A start while busy must not disturb the latched operands.
        exp_q.push_back(32'd100);
        name_q.push_back("divu_ignore");
        issue(DIVU, 32'd1000, 32'd10);
        repeat (9) @(posedge clk);
        #1;
        bus.i_op    = DIV;
        bus.i_a     = 32'd5;
        bus.i_b     = 32'd1;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        begin
            int lat = 0;
            @(negedge clk);
            while (!bus.o_valid && lat < 60) begin
                @(negedge clk);
                lat++;
            end
            check("ignore_lat", 32'(lat), 32'd24);
        end
        @(posedge clk);
        #1;

        // Flush mid-CALC: no pulse, back to IDLE, old result kept.
        valid_snap = n_valid;
        issue(DIVU, 32'd77, 32'd7);
        repeat (14) @(posedge clk);
        #1 bus.i_flush = 1'b1;
        @(posedge clk);
        #1 bus.i_flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 32'(bus.o_busy), 32'd0);
        check("flush_state", 32'(bus.dbg_state), 32'(IDLE));
        repeat (40) @(negedge clk);
        check("flush_no_valid", 32'(n_valid), 32'(valid_snap));
        check("flush_result", bus.o_result, 32'd100);

        // Flush together with start in IDLE: nothing accepted.
        @(negedge clk);
        bus.i_op    = DIVU;
        bus.i_a     = 32'd4;
        bus.i_b     = 32'd2;
        bus.i_start = 1'b1;
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
        @(negedge clk);
        check("flush_start_busy", 32'(bus.o_busy), 32'd0);
        repeat (40) @(negedge clk);
        check("flush_start_no_valid", 32'(n_valid), 32'(valid_snap));

        // Asynchronous reset mid-CALC clears state and result without a clock edge.
        run_op("divu_big", DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 34);
        valid_snap = n_valid;
        issue(DIVU, 32'd50, 32'd5);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("mid_busy", 32'(bus.o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.o_busy), 32'd0);
        check("arst_result", bus.o_result, 32'd0);
        check("arst_state", 32'(bus.dbg_state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("arst_no_valid", 32'(n_valid), 32'(valid_snap));
        run_op("divu_9_3", DIVU, 32'd9, 32'd3, 32'd3, 34);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
